// File: rtl/adc_pattern_gen.sv
// rtl/adc_pattern_gen.sv - multi-channel ADC test-pattern generator with 3-wire SPI config
module adc_pattern_gen #(
  parameter int DATA_W = 14,
  parameter int NUM_CH = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     csb,
  input  logic                     sdio,
  input  logic                     pdwn,
  input  logic                     sync,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     ch_valid,
  output logic [NUM_CH-1:0]        ch_or,
  output logic [DATA_W-1:0]        mux_data,
  output logic [CH_W-1:0]          mux_ch,
  output logic                     mux_or,
  output logic                     mux_frame
);

  localparam logic [CH_W-1:0] LAST_SEL = CH_W'(NUM_CH - 1);

  // SPI pins are asynchronous to clk; bit [1] is the synced value, bit [2] its previous cycle
  logic [2:0] sclk_sy;
  logic [2:0] csb_sy;
  logic [1:0] sdio_sy;
  logic       sclk_rise;
  logic       csb_low;
  logic       csb_rise;

  // The shift register keeps the 15 frame bits we decode; the R/W bit falls off the top
  logic [14:0] spi_sr;
  logic [4:0]  bit_cnt;
  logic        commit;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  logic [2:0]  mode_q;
  logic [7:0]  mask_q;
  logic [7:0]  const_lo_q;
  logic [7:0]  const_hi_q;
  logic [7:0]  step_q;
  logic        reseed;

  logic [DATA_W-1:0] ramp_q;
  logic              cb_q;
  logic [22:0]       lfsr_q;
  logic [CH_W-1:0]   sel_q;
  logic [CH_W-1:0]   sel_nxt;
  logic              wrap;

  logic [22:0]              const_ext;
  logic [DATA_W-1:0]        cb_a;
  logic [DATA_W-1:0]        pat_val;
  logic [DATA_W-1:0]        ch_tmp;
  logic [NUM_CH*DATA_W-1:0] next_data;
  logic [NUM_CH-1:0]        next_or;
  logic [NUM_CH*DATA_W-1:0] mux_src;
  logic [NUM_CH-1:0]        or_src;
  logic                     unused_ok;

  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
  assign csb_low   = ~csb_sy[1];
  assign csb_rise  = csb_sy[1] & ~csb_sy[2];
  assign commit    = csb_rise && (bit_cnt == 5'd16);
  assign wr_addr   = spi_sr[14:8];
  assign wr_data   = spi_sr[7:0];
  assign reseed    = sync | (commit && (wr_addr == 7'h00));
  assign const_ext = {7'd0, const_hi_q, const_lo_q};
  assign wrap      = (sel_q == LAST_SEL);
  assign sel_nxt   = wrap ? '0 : sel_q + 1'b1;
  assign unused_ok = ^{const_ext, lfsr_q, mask_q, step_q};

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy <= 3'b000;
      csb_sy  <= 3'b111;
      sdio_sy <= 2'b00;
    end else begin
      sclk_sy <= {sclk_sy[1:0], sclk};
      csb_sy  <= {csb_sy[1:0], csb};
      sdio_sy <= {sdio_sy[0], sdio};
    end
  end

  // Shift sdio on synced sclk rise while selected; the counter clears whenever csb is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sr  <= '0;
      bit_cnt <= '0;
    end else if (!csb_low) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      spi_sr  <= {spi_sr[13:0], sdio_sy[1]};
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Register file, written only by a complete 16-bit frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 3'd1;
      mask_q     <= 8'hFF;
      const_lo_q <= 8'h00;
      const_hi_q <= 8'h00;
      step_q     <= 8'h01;
    end else if (commit) begin
      case (wr_addr)
        7'h00:   mode_q     <= wr_data[2:0];
        7'h01:   mask_q     <= wr_data;
        7'h02:   const_lo_q <= wr_data;
        7'h03:   const_hi_q <= wr_data;
        7'h04:   step_q     <= wr_data;
        default: ;
      endcase
    end
  end

  // Frame counter and pattern state; reseed wins over power-down freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      ramp_q <= '0;
      cb_q   <= 1'b0;
      lfsr_q <= '1;
    end else if (reseed) begin
      sel_q  <= '0;
      ramp_q <= '0;
      cb_q   <= 1'b0;
      lfsr_q <= '1;
    end else if (!pdwn) begin
      sel_q <= sel_nxt;
      if (wrap) begin
        ramp_q <= ramp_q + DATA_W'(step_q);
        cb_q   <= ~cb_q;
        lfsr_q <= {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
      end
    end
  end

  // Current pattern value and its per-channel derivation (odd channels inverted, masked)
  always_comb begin
    cb_a      = '0;
    pat_val   = '0;
    ch_tmp    = '0;
    next_data = '0;
    next_or   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cb_a[i] = ((i % 2) == 0);
    end
    case (mode_q)
      3'd1:    pat_val = ramp_q;
      3'd2:    pat_val = cb_q ? ~cb_a : cb_a;
      3'd3:    pat_val = const_ext[DATA_W-1:0];
      3'd4:    pat_val = lfsr_q[DATA_W-1:0];
      default: pat_val = '0;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      ch_tmp = ((k % 2) == 1) ? ~pat_val : pat_val;
      if (!mask_q[k]) begin
        ch_tmp = '0;
      end
      next_data[k*DATA_W +: DATA_W] = ch_tmp;
      next_or[k] = mask_q[k] && ((&ch_tmp) || (~|ch_tmp));
    end
    mux_src = wrap ? next_data : ch_data;
    or_src  = wrap ? next_or : ch_or;
  end

  // Registered outputs: new sample at wrap, interleaved view follows sel one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data   <= '0;
      ch_valid  <= 1'b0;
      ch_or     <= '0;
      mux_data  <= '0;
      mux_ch    <= '0;
      mux_or    <= 1'b0;
      mux_frame <= 1'b0;
    end else if (pdwn) begin
      ch_data   <= '0;
      ch_valid  <= 1'b0;
      ch_or     <= '0;
      mux_data  <= '0;
      mux_ch    <= sel_q;
      mux_or    <= 1'b0;
      mux_frame <= 1'b0;
    end else if (reseed) begin
      ch_valid  <= 1'b0;
      mux_frame <= 1'b0;
    end else begin
      ch_valid  <= wrap;
      mux_frame <= wrap;
      if (wrap) begin
        ch_data <= next_data;
        ch_or   <= next_or;
      end
      mux_ch   <= sel_nxt;
      mux_data <= mux_src[int'(sel_nxt)*DATA_W +: DATA_W];
      mux_or   <= or_src[sel_nxt];
    end
  end

endmodule

// File: doc/adc_pattern_gen.md
# adc_pattern_gen

Parametrised multi-channel ADC data-pattern generator: the next-generation AD9643-style stimulus model, synthesisable and single-clock. Produces NUM_CH channels of DATA_W-bit test patterns (ramp, checkerboard, constant, PN23) selected through a 3-wire SPI register write. Outputs are presented both as a parallel sample word and as a channel-interleaved stream that mimics a DDR ADC port. Used in DSP front-end benches and loopback builds in place of the physical converter.

## Interface
- DATA_W, 14, sample width (4..23)
- NUM_CH, 2, channel count (1..8); CH_W = max(1, clog2(NUM_CH))
- clk  input  1  sample clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock, asynchronous, at most clk/4
- csb  input  1  SPI chip select, active low, asynchronous
- sdio  input  1  SPI data in, MSB first, sampled on sclk rising
- pdwn  input  1  power-down, synchronous to clk
- sync  input  1  pattern restart, synchronous to clk, level
- ch_data  output  NUM_CH*DATA_W  parallel sample, channel k at [k*DATA_W +: DATA_W]
- ch_valid  output  1  one-cycle strobe, ch_data is a new sample
- ch_or  output  NUM_CH  per-channel overrange flag
- mux_data  output  DATA_W  interleaved channel data
- mux_ch  output  CH_W  channel index of mux_data
- mux_or  output  1  overrange of the channel on mux_data
- mux_frame  output  1  high when mux_ch == 0 (equals ch_valid)

## Operation
- Registers (8-bit, addressed): 0x00 mode[2:0] (reset 1); 0x01 channel enable mask (reset all ones); 0x02 const[7:0] (reset 0); 0x03 const[15:8] (reset 0); 0x04 ramp step (reset 1). Other addresses ignored.
- SPI: sclk, csb, sdio each pass through a 2-flop synchroniser; synced sclk rising edge shifts sdio into a 16-bit shift register and increments a 5-bit bit counter, both while synced csb is low. Frame = bit15 R/W (ignored, writes only), bits14:8 address, bits7:0 data.
- On synced csb rising edge: commit the write only if the bit counter == 16; otherwise discard. The counter clears whenever csb is high.
- Writes to 0x00 also reseed the pattern (same effect as sync).
- Modes: 0 zero; 1 ramp: value += step mod 2^DATA_W, starting at 0; 2 checkerboard: alternates between A = ...0101 (bit0 = 1) and ~A, starting with A; 3 constant: const[DATA_W-1:0]; 4 PN23: LFSR x^23+x^18+1, seed all ones, one step per sample, output the low DATA_W bits; 5-7 behave as mode 0.
- Channel derivation: even channels carry the pattern value; odd channels carry its bitwise complement. A disabled channel outputs 0 and its or flag is 0.
- Overrange: ch_or[k] = 1 when the enabled channel's value is all ones or all zeros.
- Frame counter sel counts 0..NUM_CH-1, wrapping. At wrap, the next sample loads into ch_data, ch_valid pulses, and the pattern advances one step.
- Interleave: each cycle mux_data/mux_or/mux_ch present channel sel of the current ch_data, so channel 0 appears in the ch_valid cycle, channel 1 in the next cycle, and so on.
- pdwn high: sel and pattern state freeze; ch_data, mux_data, ch_or, mux_or, ch_valid and mux_frame are forced to 0; the register file and SPI keep running. On release, operation resumes from the frozen state.
- sync high (and reseed): pattern returns to its seed and sel to its post-reset value. The registers are not affected.

## Timing
- Reset: every output 0; sel = 0; pattern at seed; registers at their reset values.
- The first ch_valid occurs on the NUM_CH-th rising edge after rst_n deassertion and carries sample 0 (ramp 0: ch0 = 0x0000, ch1 = 0x3FFF for DATA_W = 14). Later strobes follow every NUM_CH cycles.
- ch_data, ch_valid and all mux outputs are registered: 1-cycle latency from the sel state.
- SPI write takes effect at most 4 clk cycles after the csb pin rises. A mode change reseeds the pattern; the first new sample appears NUM_CH cycles after the reseed.
- If sync and an SPI commit occur in the same cycle, the register write completes and a single reseed is applied.
- If pdwn and sync occur in the same cycle, the reseed applies and outputs stay 0 until pdwn falls.
- NUM_CH = 1: sel is constant 0, ch_valid is high every cycle, and mux_ch = 0.
- Ramp wraps from 2^DATA_W-1 to 0 with no flag beyond ch_or.
- Asserting rst_n low mid-SPI-frame aborts the frame with no write.

## Test plan
- Reset, default config, DATA_W = 14, NUM_CH = 2 -> ch_valid every 2 clk; ch0 = 0, 1, 2...; ch1 = 0x3FFF, 0x3FFE...; ch_or[0] = 1 on sample 0; mux alternates ch0/ch1.
- SPI write 0x0004 = 0x05, then 0x0000 = 0x03 with const 0x1234 -> ch0 = 0x1234 and ch1 = 0x2DCB steady, both within 4 clk + NUM_CH of the csb rise.
- 15-bit and 17-bit SPI frames -> no register change; ramp continues uninterrupted.
- Mode 2 -> ch0 alternates 0x1555/0x2AAA; set mask 0x01 -> ch1 = 0 and ch_or[1] = 0.
- Mode 4 -> first 4 ch0 samples match a reference PN23 model from seed all ones; pulse sync -> sequence restarts from the seed.
- Ramp step 0xFF running, pdwn high 10 cycles -> all data 0, no ch_valid; release -> ramp continues from the frozen value; rst_n low mid-frame -> all outputs 0 immediately.
